tone_channel_arbiter: RTL and testbench
=======================================

Name: tone_channel_arbiter

Overview:
- Shares the single piezo/LED note channel among three requesters: keypad echo (0), melody playback sequencer (1), and effect/jingle generator for miss and game end (2).
- Grants one note at a time with fixed priority. Times each note in ticks derived from clk. Inserts a silent gap between notes.
- Signals completion or abort back to each requester.
- Sits between the game controller and the piezo/LED drivers.

Parameters:
- TICK_DIV, 500000, clk cycles per tick (>=2)
- GAP_TICKS, 1, silent ticks after each completed note (0 = no gap)
- CW, 20, width of the cycle counter; must satisfy 2^CW >= TICK_DIV

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  3  per-requester note request, level; bit i = requester i
- note_key  in  4  keypad note code (0 = rest, 1-8 = pitch)
- note_play  in  4  playback note code
- note_fx  in  4  effect note code
- len_key  in  3  keypad note length in ticks
- len_play  in  3  playback note length in ticks
- len_fx  in  3  effect note length in ticks
- gnt  out  3  one-hot, one-cycle pulse; request accepted
- done  out  3  one-hot, one-cycle pulse; granted note finished normally
- abrt  out  3  one-hot, one-cycle pulse; granted note cut short by preemption
- piezo_out  out  4  active note code to the piezo driver
- led_out  out  4  mirror of piezo_out
- owner  out  2  index of the current grant holder; 3 = none
- busy  out  1  high in PLAY or GAP

Behaviour:
- Reset (asynchronous, active-high): state IDLE; gnt, done and abrt are 0; piezo_out and led_out are 0; owner = 3; busy = 0; all counters 0. Reset mid-note silences the channel immediately. No done or abrt pulse is issued on reset.
- All outputs are registered.
- States: IDLE, PLAY, GAP.
- IDLE:
  - On an edge with any req bit high, grant the highest priority. Priority order: 2 > 0 > 1.
  - At that edge: gnt[i] <= 1; latch note_i into piezo_out/led_out; latch len_i (len 0 is treated as 1); owner <= i; cycle counter and tick counter <= 0; go to PLAY.
  - Grant latency is 1 edge; gnt and the new note appear together.
- PLAY:
  - The cycle counter counts 0..TICK_DIV-1 and wraps. Each wrap increments the tick counter.
  - Exit condition: the tick counter equals len-1 and the cycle counter equals TICK_DIV-1.
  - At the exit edge: piezo_out/led_out <= 0; done[owner] <= 1; go to GAP, or go to IDLE with owner <= 3 if GAP_TICKS = 0.
  - The note is therefore audible for exactly len*TICK_DIV cycles.
- GAP:
  - Silent for GAP_TICKS*TICK_DIV cycles. Then go to IDLE with owner <= 3.
  - Requests are not serviced in GAP, including effect requests.
- Note onset spacing for back-to-back notes is len*TICK_DIV + GAP_TICKS*TICK_DIV + 1 cycles.
- Preemption:
  - Applies only in PLAY, when owner != 2 and req[2] = 1.
  - At that edge: abrt[owner] <= 1 and gnt[2] <= 1 together; latch note_fx and len_fx; counters <= 0; stay in PLAY.
  - No done pulse is issued for the aborted note.
  - An effect note is never preempted.
- A requester may drop req after the grant; the committed note still plays to completion.
- Handshake rule: in the cycle after it sees gnt, a requester drops req or presents its next note and length. If req is still high when the arbiter returns to IDLE, it is granted again.
- Note code 0 is a rest: identical timing and pulses, with the piezo silent.
- There is no fairness guarantee. Sustained keypad requests starve playback; this is intended, because keypad input is locked out during playback upstream.
- Note and length inputs are sampled only at grant; changes during PLAY are ignored.
- gnt, done and abrt are never high for more than one cycle. At most one bit of each is set.

Test Plan:
All scenarios use TICK_DIV=4 and GAP_TICKS=1.
1. req=001, note_key=5, len_key=2 for one cycle, then req=000 -> gnt=001 for 1 cycle; piezo_out=led_out=5 for 8 cycles; then done=001 for 1 cycle with piezo 0; busy is high for 12 cycles, then owner=3.
2. req=011 held, with req[0] dropped after its gnt -> gnt=001 first; gnt=010 exactly 13 cycles later (len_key=2, len_play=1); piezo then shows note_play for 4 cycles.
3. Playback note 3, len_play=3 is granted; 5 cycles later req[2] rises with note_fx=7, len_fx=1 -> abrt=010 and gnt=100 in the same cycle; piezo=7 for 4 cycles; done=100 follows; no done[1] pulse.
4. len_key=0, note_key=2 -> piezo=2 for exactly 4 cycles, then done=001.
5. Reset asserted 3 cycles into an 8-cycle note -> piezo_out=0, owner=3 and busy=0 asynchronously; no done or abrt pulse; a fresh req is granted on the first edge after reset deasserts.
6. note_play=0, len_play=2 -> piezo stays 0 throughout; gnt and done pulses are still spaced 8 cycles apart.

Source files
------------

// File: rtl/tone_channel_arbiter.sv
// tone_channel_arbiter: shares one piezo/LED note channel among three requesters.
// Requesters: 0 = keypad echo, 1 = melody playback, 2 = effect/jingle.
// Fixed priority 2 > 0 > 1. An effect request preempts a non-effect note in PLAY.
// Each note lasts len*TICK_DIV cycles and is followed by GAP_TICKS*TICK_DIV silent cycles.
//
// state | meaning
// IDLE  | channel free, grant highest-priority request on the next edge
// PLAY  | note audible, cycle/tick counters running
// GAP   | silent spacer after a completed note, requests held off
module tone_channel_arbiter #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 1,
    parameter int CW        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [3:0] note_key,
    input  logic [3:0] note_play,
    input  logic [3:0] note_fx,
    input  logic [2:0] len_key,
    input  logic [2:0] len_play,
    input  logic [2:0] len_fx,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic [2:0] abrt,
    output logic [3:0] piezo_out,
    output logic [3:0] led_out,
    output logic [1:0] owner,
    output logic       busy
);

    // Tick counter is shared by note length and gap length, so it must hold GAP_TICKS-1.
    localparam int TW = 16;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state_q;
    logic [CW-1:0] cyc_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    len_last_q;
    logic [3:0]    note_q;
    logic [1:0]    owner_q;
    logic          busy_q;
    logic [2:0]    gnt_q;
    logic [2:0]    done_q;
    logic [2:0]    abrt_q;

    logic [1:0]    sel_idx_d;
    logic [3:0]    sel_note_d;
    logic [2:0]    sel_len_last_d;
    logic [2:0]    fx_len_last_d;

    // A zero length plays as one tick; store the last tick index directly.
    function automatic logic [2:0] last_of(input logic [2:0] len);
        return (len == 3'd0) ? 3'd0 : len - 3'd1;
    endfunction

    // Fixed-priority selection among pending requests (2 > 0 > 1).
    always_comb begin
        sel_idx_d      = 2'd1;
        sel_note_d     = note_play;
        sel_len_last_d = last_of(len_play);
        fx_len_last_d  = last_of(len_fx);
        if (req[2]) begin
            sel_idx_d      = 2'd2;
            sel_note_d     = note_fx;
            sel_len_last_d = fx_len_last_d;
        end else if (req[0]) begin
            sel_idx_d      = 2'd0;
            sel_note_d     = note_key;
            sel_len_last_d = last_of(len_key);
        end
    end

    // Channel FSM with note timing and registered handshake pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            tick_q     <= '0;
            len_last_q <= '0;
            note_q     <= '0;
            owner_q    <= 2'd3;
            busy_q     <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            abrt_q     <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            abrt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q      <= 3'b001 << sel_idx_d;
                        note_q     <= sel_note_d;
                        len_last_q <= sel_len_last_d;
                        owner_q    <= sel_idx_d;
                        cyc_q      <= '0;
                        tick_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= PLAY;
                    end
                end
                PLAY: begin
                    if (req[2] && owner_q != 2'd2) begin
                        abrt_q     <= 3'b001 << owner_q;
                        gnt_q      <= 3'b100;
                        note_q     <= note_fx;
                        len_last_q <= fx_len_last_d;
                        owner_q    <= 2'd2;
                        cyc_q      <= '0;
                        tick_q     <= '0;
                    end else if (cyc_q == CYC_LAST) begin
                        cyc_q <= '0;
                        if (tick_q == TW'(len_last_q)) begin
                            note_q <= '0;
                            done_q <= 3'b001 << owner_q;
                            tick_q <= '0;
                            if (GAP_TICKS == 0) begin
                                owner_q <= 2'd3;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= GAP;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_q <= '0;
                        if (tick_q == GAP_LAST) begin
                            tick_q  <= '0;
                            owner_q <= 2'd3;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign abrt      = abrt_q;
    assign piezo_out = note_q;
    assign led_out   = note_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tone_channel_arbiter.sv
// Directed bench for tone_channel_arbiter with TICK_DIV=4, GAP_TICKS=1.
module tb_tone_channel_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [3:0] note_key, note_play, note_fx;
    logic [2:0] len_key, len_play, len_fx;
    logic [2:0] gnt, done, abrt;
    logic [3:0] piezo_out, led_out;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tone_channel_arbiter #(.TICK_DIV(4), .GAP_TICKS(1), .CW(20)) dut (
        .clk(clk), .reset(reset), .req(req),
        .note_key(note_key), .note_play(note_play), .note_fx(note_fx),
        .len_key(len_key), .len_play(len_play), .len_fx(len_fx),
        .gnt(gnt), .done(done), .abrt(abrt),
        .piezo_out(piezo_out), .led_out(led_out), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || owner !== 2'd3) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || owner !== 2'd3) begin
            errors++;
            $display("FAIL wait_idle: busy=%b owner=%0d, required busy=0 owner=3", busy, owner);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0;
        note_key = '0; note_play = '0; note_fx = '0;
        len_key = '0; len_play = '0; len_fx = '0;
        #1;
        checks++;
        if ({gnt, done, abrt, piezo_out, led_out, owner, busy} !== {9'b0, 8'b0, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: gnt=%b done=%b abrt=%b piezo=%0d led=%0d owner=%0d busy=%b, required all 0 owner=3",
                     gnt, done, abrt, piezo_out, led_out, owner, busy);
        end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_note();
        int busy_cnt = 0;
        req = 3'b001; note_key = 4'd5; len_key = 3'd2;
        step();
        req = 3'b000;
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b, required 001/0/1", gnt, owner, busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (piezo_out !== 4'd5 || led_out !== 4'd5 || done !== 3'b000) begin
                errors++;
                $display("FAIL single_play[%0d]: piezo=%0d led=%0d done=%b, required 5/5/000", i, piezo_out, led_out, done);
            end
        end
        step();
        if (busy === 1'b1) busy_cnt++;
        checks++;
        if (done !== 3'b001 || piezo_out !== 4'd0 || led_out !== 4'd0) begin
            errors++;
            $display("FAIL single_done: done=%b piezo=%0d led=%0d, required 001/0/0", done, piezo_out, led_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 12 || owner !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: busy cycles=%0d owner=%0d busy=%b, required 12/3/0", busy_cnt, owner, busy);
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        req = 3'b011; note_key = 4'd1; len_key = 3'd2; note_play = 4'd6; len_play = 3'd1;
        step();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL b2b_first_gnt: gnt=%b, required 001", gnt);
        end
        req = 3'b010;
        while (gnt !== 3'b010 && gap < 40) begin
            step();
            gap++;
        end
        req = 3'b000;
        checks++;
        if (gap != 13 || piezo_out !== 4'd6 || owner !== 2'd1) begin
            errors++;
            $display("FAIL b2b_second_gnt: spacing=%0d piezo=%0d owner=%0d, required 13/6/1", gap, piezo_out, owner);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (piezo_out !== 4'd6 || done !== 3'b000) begin
                errors++;
                $display("FAIL b2b_play[%0d]: piezo=%0d done=%b, required 6/000", i, piezo_out, done);
            end
        end
        step();
        checks++;
        if (done !== 3'b010 || piezo_out !== 4'd0) begin
            errors++;
            $display("FAIL b2b_done: done=%b piezo=%0d, required 010/0", done, piezo_out);
        end
        wait_idle();
    endtask

    task automatic test_preempt();
        int done1 = 0;
        req = 3'b010; note_play = 4'd3; len_play = 3'd3;
        step();
        req = 3'b000;
        checks++;
        if (gnt !== 3'b010 || piezo_out !== 4'd3) begin
            errors++;
            $display("FAIL preempt_first_gnt: gnt=%b piezo=%0d, required 010/3", gnt, piezo_out);
        end
        for (int i = 0; i < 4; i++) step();
        req = 3'b100; note_fx = 4'd7; len_fx = 3'd1;
        step();
        req = 3'b000;
        checks++;
        if (abrt !== 3'b010 || gnt !== 3'b100 || piezo_out !== 4'd7 || owner !== 2'd2 || done !== 3'b000) begin
            errors++;
            $display("FAIL preempt_edge: abrt=%b gnt=%b piezo=%0d owner=%0d done=%b, required 010/100/7/2/000",
                     abrt, gnt, piezo_out, owner, done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (done[1] === 1'b1) done1++;
            checks++;
            if (piezo_out !== 4'd7 || abrt !== 3'b000 || done !== 3'b000) begin
                errors++;
                $display("FAIL preempt_fx_play[%0d]: piezo=%0d abrt=%b done=%b, required 7/000/000", i, piezo_out, abrt, done);
            end
        end
        step();
        checks++;
        if (done !== 3'b100 || piezo_out !== 4'd0) begin
            errors++;
            $display("FAIL preempt_fx_done: done=%b piezo=%0d, required 100/0", done, piezo_out);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (done[1] === 1'b1) done1++;
        end
        checks++;
        if (done1 != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL preempt_no_done1: done[1] pulses=%0d busy=%b, required 0/0", done1, busy);
        end
    endtask

    task automatic test_len_zero();
        req = 3'b001; note_key = 4'd2; len_key = 3'd0;
        step();
        req = 3'b000;
        checks++;
        if (gnt !== 3'b001 || piezo_out !== 4'd2) begin
            errors++;
            $display("FAIL len0_grant: gnt=%b piezo=%0d, required 001/2", gnt, piezo_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (piezo_out !== 4'd2 || done !== 3'b000) begin
                errors++;
                $display("FAIL len0_play[%0d]: piezo=%0d done=%b, required 2/000", i, piezo_out, done);
            end
        end
        step();
        checks++;
        if (done !== 3'b001 || piezo_out !== 4'd0) begin
            errors++;
            $display("FAIL len0_done: done=%b piezo=%0d, required 001/0", done, piezo_out);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_note();
        req = 3'b001; note_key = 4'd4; len_key = 3'd2;
        step();
        req = 3'b000;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (piezo_out !== 4'd0 || led_out !== 4'd0 || owner !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: piezo=%0d led=%0d owner=%0d busy=%b, required 0/0/3/0", piezo_out, led_out, owner, busy);
        end
        step();
        checks++;
        if (done !== 3'b000 || abrt !== 3'b000 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%b abrt=%b gnt=%b, required 000/000/000", done, abrt, gnt);
        end
        reset = 1'b0;
        req = 3'b001; note_key = 4'd8; len_key = 3'd1;
        step();
        req = 3'b000;
        checks++;
        if (gnt !== 3'b001 || piezo_out !== 4'd8 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_regrant: gnt=%b piezo=%0d owner=%0d, required 001/8/0", gnt, piezo_out, owner);
        end
        wait_idle();
    endtask

    task automatic test_rest_note();
        int spacing = 0;
        int loud = 0;
        req = 3'b010; note_play = 4'd0; len_play = 3'd2;
        step();
        req = 3'b000;
        checks++;
        if (gnt !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rest_grant: gnt=%b busy=%b, required 010/1", gnt, busy);
        end
        while (done === 3'b000 && spacing < 40) begin
            if (piezo_out !== 4'd0) loud++;
            step();
            spacing++;
        end
        checks++;
        if (spacing != 8 || done !== 3'b010 || loud != 0) begin
            errors++;
            $display("FAIL rest_timing: spacing=%0d done=%b loud cycles=%0d, required 8/010/0", spacing, done, loud);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_back_to_back();
        test_preempt();
        test_len_zero();
        test_reset_mid_note();
        test_rest_note();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
